// File: rtl/sysarray_feeder_if.sv
// Write-port and slice-stream bundle between the operand loader, the feeder and sysarray.
interface sysarray_feeder_if #(
  parameter int N = 31,
  parameter int n = 2
);
  logic                 wr_en;
  logic                 wr_sel;
  logic [5:0]           wr_row;
  logic [5:0]           wr_col;
  logic [N:0]           wr_data;
  logic                 start;
  logic                 busy;
  logic                 done;
  logic [6:0]           flg;
  logic [(N+1)*n-1:0]   arr1;
  logic [(N+1)*n-1:0]   arr2;

  modport master (
    output wr_en, wr_sel, wr_row, wr_col, wr_data, start,
    input  busy, done, flg, arr1, arr2
  );

  modport slave (
    input  wr_en, wr_sel, wr_row, wr_col, wr_data, start,
    output busy, done, flg, arr1, arr2
  );
endinterface

// File: rtl/sysarray_feeder.sv
// Holds operand matrices A and B and streams one k-slice per clock into sysarray,
// followed by zero drain slices and a one-cycle done pulse.
module sysarray_feeder #(
  parameter int N     = 31,
  parameter int n     = 2,
  parameter int DRAIN = 2*n-1
) (
  input logic              clk,
  input logic              rst,
  sysarray_feeder_if.slave bus
);
  localparam int         W    = N + 1;
  localparam logic [6:0] LAST = 7'(n + DRAIN - 1);

  typedef enum logic [1:0] {S_IDLE, S_STREAM, S_DONE} state_e;

  state_e          state_q, state_d;
  logic [6:0]      flg_q, flg_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [W*n-1:0]  arr1_q, arr1_d;
  logic [W*n-1:0]  arr2_q, arr2_d;

  logic [N:0] a_q   [n][n];
  logic [N:0] b_q   [n][n];
  logic [N:0] a_fwd [n][n];
  logic [N:0] b_fwd [n][n];
  logic       wr_a, wr_b;

  assign wr_a = (state_q == S_IDLE) && bus.wr_en && !bus.wr_sel;
  assign wr_b = (state_q == S_IDLE) && bus.wr_en &&  bus.wr_sel;

  // Storage with the pending write folded in, so a write coinciding with start
  // is already visible in slice 0; out-of-range indices never match a cell.
  always_comb begin
    for (int unsigned i = 0; i < n; i++) begin
      for (int unsigned j = 0; j < n; j++) begin
        a_fwd[i][j] = a_q[i][j];
        b_fwd[i][j] = b_q[i][j];
        if ((32'(bus.wr_row) == i) && (32'(bus.wr_col) == j)) begin
          if (wr_a) a_fwd[i][j] = bus.wr_data;
          if (wr_b) b_fwd[i][j] = bus.wr_data;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < n; i++) begin
      for (int unsigned j = 0; j < n; j++) begin
        if (rst) begin
          a_q[i][j] <= '0;
          b_q[i][j] <= '0;
        end else begin
          a_q[i][j] <= a_fwd[i][j];
          b_q[i][j] <= b_fwd[i][j];
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    flg_d   = flg_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    arr1_d  = '0;
    arr2_d  = '0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_STREAM;
          flg_d   = '0;
          busy_d  = 1'b1;
        end
      end
      S_STREAM: begin
        if (flg_q == LAST) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          flg_d  = flg_q + 7'd1;
          busy_d = 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Data slices only for steps below n; drain steps leave the buses at zero.
    if (busy_d) begin
      for (int unsigned kk = 0; kk < n; kk++) begin
        if (flg_d == 7'(kk)) begin
          for (int unsigned i = 0; i < n; i++) begin
            arr1_d[i*W +: W] = a_fwd[i][kk];
            arr2_d[i*W +: W] = b_fwd[kk][i];
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      flg_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      arr1_q  <= '0;
      arr2_q  <= '0;
    end else begin
      state_q <= state_d;
      flg_q   <= flg_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      arr1_q  <= arr1_d;
      arr2_q  <= arr2_d;
    end
  end

  assign bus.flg  = flg_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.arr1 = arr1_q;
  assign bus.arr2 = arr2_q;
endmodule

// File: tb/tb_sysarray_feeder.sv
// Self-checking bench for sysarray_feeder with n=2, 32-bit elements.
module tb_sysarray_feeder;
  localparam int N  = 31;
  localparam int NN = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sysarray_feeder_if #(.N(N), .n(NN)) bus();

  sysarray_feeder #(.N(N), .n(NN), .DRAIN(2*NN-1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct packed {
    logic [6:0]  flg;
    logic        busy;
    logic        done;
    logic [63:0] arr1;
    logic [63:0] arr2;
  } exp_t;

  // Matrices in row-major order {x11,x10,x01,x00}; expected slices as {lane1,lane0}.
  typedef struct packed {
    logic [3:0][31:0] a;
    logic [3:0][31:0] b;
    logic [63:0]      s0a1, s0a2, s1a1, s1a2;
  } vec_t;

  exp_t q[$];
  vec_t vecs[3];
  int   checks = 0;
  int   errors = 0;

  function automatic exp_t mk(input logic [6:0] f, input logic bz, input logic dn,
                              input logic [63:0] a1, input logic [63:0] a2);
    exp_t e;
    e.flg = f; e.busy = bz; e.done = dn; e.arr1 = a1; e.arr2 = a2;
    return e;
  endfunction

  task automatic check(input string nm, input exp_t e);
    checks++;
    if (bus.flg !== e.flg || bus.busy !== e.busy || bus.done !== e.done ||
        bus.arr1 !== e.arr1 || bus.arr2 !== e.arr2) begin
      errors++;
      $display("FAIL %s: got flg=%0d busy=%b done=%b arr1=%h arr2=%h, expected flg=%0d busy=%b done=%b arr1=%h arr2=%h",
               nm, bus.flg, bus.busy, bus.done, bus.arr1, bus.arr2,
               e.flg, e.busy, e.done, e.arr1, e.arr2);
    end
  endtask

  task automatic wr(input logic sel, input logic [5:0] row, input logic [5:0] col,
                    input logic [31:0] data);
    bus.wr_sel  = sel;
    bus.wr_row  = row;
    bus.wr_col  = col;
    bus.wr_data = data;
    bus.wr_en   = 1'b1;
    @(negedge clk);
    bus.wr_en   = 1'b0;
  endtask

  task automatic push_stream(input logic [63:0] s0a1, input logic [63:0] s0a2,
                             input logic [63:0] s1a1, input logic [63:0] s1a2);
    q.push_back(mk(7'd0, 1'b1, 1'b0, s0a1, s0a2));
    q.push_back(mk(7'd1, 1'b1, 1'b0, s1a1, s1a2));
    for (int k = 2; k <= 4; k++) q.push_back(mk(7'(k), 1'b1, 1'b0, '0, '0));
    q.push_back(mk(7'd4, 1'b0, 1'b1, '0, '0));
    q.push_back(mk(7'd4, 1'b0, 1'b0, '0, '0));
  endtask

  // One expected record per cycle; optional write or start release after a given index.
  task automatic drain(input string tag, input int wr_at, input int stop_at);
    int idx = 0;
    while (q.size() > 0) begin
      check($sformatf("%s_cyc%0d", tag, idx), q.pop_front());
      if (idx == wr_at) begin
        bus.wr_sel = 1'b0; bus.wr_row = 6'd0; bus.wr_col = 6'd0;
        bus.wr_data = 32'd99; bus.wr_en = 1'b1;
      end else begin
        bus.wr_en = 1'b0;
      end
      if (idx == stop_at) bus.start = 1'b0;
      idx++;
      @(negedge clk);
    end
    bus.wr_en = 1'b0;
  endtask

  task automatic run_stream(input string tag, input vec_t v, input int wr_at);
    bus.start = 1'b1;
    push_stream(v.s0a1, v.s0a2, v.s1a1, v.s1a2);
    @(negedge clk);
    bus.start = 1'b0;
    drain(tag, wr_at, -1);
  endtask

  initial begin
    vecs[0].a = {32'd13, 32'd12, 32'd11, 32'd10};
    vecs[0].b = {32'd23, 32'd22, 32'd21, 32'd20};
    vecs[0].s0a1 = {32'd12, 32'd10}; vecs[0].s0a2 = {32'd21, 32'd20};
    vecs[0].s1a1 = {32'd13, 32'd11}; vecs[0].s1a2 = {32'd23, 32'd22};
    vecs[1].a = {32'h80000000, 32'h0, 32'h0, 32'hFFFFFFFF};
    vecs[1].b = {32'h1, 32'h0, 32'hFFFFFFFF, 32'h80000000};
    vecs[1].s0a1 = {32'h0, 32'hFFFFFFFF};        vecs[1].s0a2 = {32'hFFFFFFFF, 32'h80000000};
    vecs[1].s1a1 = {32'h80000000, 32'h0};        vecs[1].s1a2 = {32'h1, 32'h0};
    vecs[2].a = {32'd4, 32'd2, 32'd3, 32'd1};
    vecs[2].b = {32'd4, 32'd2, 32'd3, 32'd1};
    vecs[2].s0a1 = {32'd2, 32'd1}; vecs[2].s0a2 = {32'd3, 32'd1};
    vecs[2].s1a1 = {32'd4, 32'd3}; vecs[2].s1a2 = {32'd4, 32'd2};

    rst = 1'b1;
    bus.wr_en = 1'b0; bus.wr_sel = 1'b0; bus.wr_row = '0; bus.wr_col = '0;
    bus.wr_data = '0; bus.start = 1'b0;
    repeat (2) @(negedge clk);
    check("reset", mk(7'd0, 1'b0, 1'b0, '0, '0));
    rst = 1'b0;
    @(negedge clk);
    check("idle_after_reset", mk(7'd0, 1'b0, 1'b0, '0, '0));

    for (int t = 0; t < 3; t++) begin
      for (int k = 0; k < 4; k++) wr(1'b0, 6'(k/2), 6'(k%2), vecs[t].a[2'(k)]);
      for (int k = 0; k < 4; k++) wr(1'b1, 6'(k/2), 6'(k%2), vecs[t].b[2'(k)]);
      run_stream($sformatf("vec%0d", t), vecs[t], -1);
    end

    // Write to A[0][0] during step 1 must not touch this or the next stream.
    run_stream("wr_busy", vecs[2], 1);
    run_stream("after_wr_busy", vecs[2], -1);

    wr(1'b0, 6'd2, 6'd0, 32'd7);
    wr(1'b1, 6'd0, 6'd2, 32'd7);
    wr(1'b0, 6'd63, 6'd63, 32'd7);
    run_stream("oob_write", vecs[2], -1);

    // Write and start on the same edge: slice 0 carries the new A[0][0].
    bus.wr_sel = 1'b0; bus.wr_row = 6'd0; bus.wr_col = 6'd0;
    bus.wr_data = 32'd5; bus.wr_en = 1'b1; bus.start = 1'b1;
    push_stream({32'd2, 32'd5}, vecs[2].s0a2, vecs[2].s1a1, vecs[2].s1a2);
    @(negedge clk);
    bus.wr_en = 1'b0; bus.start = 1'b0;
    drain("wr_with_start", -1, -1);
    wr(1'b0, 6'd0, 6'd0, 32'd1);

    // start held high: stream, done, exactly one idle cycle, identical stream.
    bus.start = 1'b1;
    push_stream(vecs[2].s0a1, vecs[2].s0a2, vecs[2].s1a1, vecs[2].s1a2);
    push_stream(vecs[2].s0a1, vecs[2].s0a2, vecs[2].s1a1, vecs[2].s1a2);
    @(negedge clk);
    drain("b2b", -1, 9);

    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check("rst_mid_step0", mk(7'd0, 1'b1, 1'b0, vecs[2].s0a1, vecs[2].s0a2));
    repeat (2) @(negedge clk);
    check("rst_mid_step2", mk(7'd2, 1'b1, 1'b0, '0, '0));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_abort", mk(7'd0, 1'b0, 1'b0, '0, '0));
    @(negedge clk);
    check("rst_no_done", mk(7'd0, 1'b0, 1'b0, '0, '0));
    bus.start = 1'b1;
    push_stream('0, '0, '0, '0);
    @(negedge clk);
    bus.start = 1'b0;
    drain("cleared", -1, -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/sysarray_feeder.md
Name: sysarray_feeder

Overview:
- Upstream operand feeder for the sysarray systolic multiplier.
- Holds two n x n operand matrices A and B, loaded through a word-write port.
- On start, streams one k-slice per clock onto the packed arr1/arr2 buses together with the flg step counter, then drives zero slices for the drain cycles.
- Outputs connect directly to sysarray's clk/flg/arr1/arr2 ports.

Parameters:
- N, 31: MSB index of one element; elements are N+1 bits wide.
- n, 2: matrix dimension and array size. Legal range 1..43, so that the last step index fits in 7-bit flg.
- DRAIN, 2*n-1: number of zero-slice cycles after the n data slices.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- wr_en  in  1  write one matrix element.
- wr_sel  in  1  0 = matrix A, 1 = matrix B.
- wr_row  in  6  row index.
- wr_col  in  6  column index.
- wr_data  in  N+1  element value.
- start  in  1  begin streaming; sampled in IDLE only.
- busy  out  1  high while streaming.
- done  out  1  one-cycle pulse after the last drain slice.
- flg  out  7  step index to sysarray.
- arr1  out  (N+1)*n  packed A slice; element i occupies bits [(i+1)*(N+1)-1 : i*(N+1)].
- arr2  out  (N+1)*n  packed B slice, same packing.

Behaviour:
- Reset is synchronous: rst high at a rising edge resets the block on that edge.
  - All registered outputs go to 0: arr1, arr2, flg, busy, done.
  - State goes to IDLE.
  - All stored A and B elements are cleared to 0.
  - rst has priority over every other input, including mid-stream; streaming aborts with no done pulse.
- Storage writes: wr_en high in IDLE at an edge stores wr_data into A[wr_row][wr_col] (wr_sel=0) or B[wr_row][wr_col] (wr_sel=1).
  - wr_row >= n or wr_col >= n: write ignored.
  - wr_en while busy: write ignored; the stream is never corrupted.
  - wr_en and start both high in IDLE at the same edge: the write is performed first, and streaming uses the updated value.
- States: IDLE, STREAM, DONE.
  - IDLE --start--> STREAM, with step k=0 loaded at that same edge.
  - STREAM: k increments each edge; at k = n+DRAIN-1, the next edge goes to DONE.
  - DONE: one cycle, then unconditionally to IDLE.
- Outputs in STREAM with step k (all registered, updated on the edge that enters step k):
  - flg = k.
  - busy = 1.
  - k < n: arr1 element i = A[i][k]; arr2 element j = B[k][j].
  - k >= n: arr1 = 0, arr2 = 0.
- Latency: start sampled at edge E0 puts slice 0 and flg=0 on the outputs immediately after E0. The last slice is visible after edge E0+n+DRAIN-1.
- DONE cycle: done=1, busy=0, arr1=arr2=0, flg holds n+DRAIN-1.
- IDLE: done=0, busy=0, arr1=arr2=0, flg holds its last value (0 after reset).
- start while busy or in DONE: ignored; it is not queued.
- start held high continuously: a new stream begins on the first IDLE edge after DONE, so one gap cycle always separates streams.
- Arithmetic: no arithmetic on data; elements pass through bit-exact. k is a 7-bit counter that cannot wrap within the legal n range.

Test Plan:
- Load, n=2: A=[[1,3],[2,4]], B=[[1,3],[2,4]], then pulse start.
  - Step 0: flg=0, arr1 elements {1,2}, arr2 elements {1,3}.
  - Step 1: flg=1, arr1 {3,4}, arr2 {2,4}.
  - flg=2,3,4: arr1=arr2=0.
  - Then done=1 for exactly one cycle with flg=4; busy=0 afterwards.
- Write during busy: issue wr_en to A[0][0]=99 at step 1 of a stream.
  - The current stream is unaffected.
  - The next stream's step 0 still shows A[0][0] equal to its pre-stream value.
- Out-of-range write: wr_row=2 with n=2 and wr_data=7 → no element of A or B changes; the next stream matches the prior contents exactly.
- Reset mid-stream: assert rst for 1 cycle at step 2.
  - Next cycle: busy=0, flg=0, arr1=arr2=0, no done pulse.
  - A subsequent stream outputs all-zero data slices, because storage was cleared.
- Back-to-back: hold start high across two streams → exactly one IDLE cycle between the done pulse and flg=0 of the second stream; the second stream repeats identical slices.
- Full width: elements 32'hFFFFFFFF and 32'h80000000 → they appear unmodified in their correct packed lanes, with no bleed into the adjacent lane.
